key_schedule_reverse: RTL

Sequential inverse S-AES key schedule. It accepts the final round key (key2) and regenerates the earlier round keys in decryption order: key2, then key1, then key0. Keys are delivered one per transfer over a valid/ready output handshake. It sits in front of the S-AES decrypt datapath, which consumes round keys last-to-first. It also lets the system store only key2 and still recover the cipher key.

---
 rtl/saes_pkg.sv | 38 +++
 rtl/nibble_substitution.sv | 19 +
 rtl/key_schedule_reverse.sv | 106 ++++++++++
 3 files changed

// File: rtl/saes_pkg.sv
// Shared S-AES definitions: nibble S-boxes, nibble helpers, round constants,
// round-key type and the reverse key schedule state encoding.
package saes_pkg;

  localparam logic [7:0] RCON1_DEF = 8'h80;
  localparam logic [7:0] RCON2_DEF = 8'h30;

  // Nibble tables packed with entry 0 in bits [3:0].
  // Forward: 0..F -> 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7
  localparam logic [63:0] SBOX     = 64'h7FEC_3026_581D_BA49;
  localparam logic [63:0] SBOX_INV = 64'hED4C_3206_F871_B95A;

  typedef logic [15:0] round_key_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT2 = 2'd1,
    ST_EMIT1 = 2'd2,
    ST_EMIT0 = 2'd3
  } state_e;

  function automatic logic [3:0] sbox_nib(input logic [3:0] n);
    return SBOX[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv_nib(input logic [3:0] n);
    return SBOX_INV[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [7:0] rot_nib(input logic [7:0] x);
    return {x[3:0], x[7:4]};
  endfunction

  function automatic logic [7:0] sub_nib(input logic [7:0] x);
    return {sbox_nib(x[7:4]), sbox_nib(x[3:0])};
  endfunction

endpackage

// File: rtl/nibble_substitution.sv
// Byte-wide S-AES nibble substitution, forward (encrypt=1) or inverse S-box.
module nibble_substitution
  import saes_pkg::*;
(
  input  logic       encrypt,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Both nibbles go through the same table; direction picks the table.
  always_comb begin
    if (encrypt) begin
      dout = {sbox_nib(din[7:4]), sbox_nib(din[3:0])};
    end else begin
      dout = {sbox_inv_nib(din[7:4]), sbox_inv_nib(din[3:0])};
    end
  end

endmodule

// File: rtl/key_schedule_reverse.sv
// Inverse S-AES key schedule: takes round key 2 and streams key2, key1, key0
// over a valid/ready handshake, one step of the inverse schedule per transfer.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after key0
// EMIT2 | key_out holds round key 2
// EMIT1 | key_out holds round key 1
// EMIT0 | key_out holds round key 0 (cipher key)
module key_schedule_reverse
  import saes_pkg::*;
#(
  parameter logic [7:0] RCON1 = RCON1_DEF,
  parameter logic [7:0] RCON2 = RCON2_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] key_in,
  output logic        busy,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [15:0] key_out,
  output logic [1:0]  key_idx,
  output logic        done
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] EMIT2 = ST_EMIT2;
  localparam logic [1:0] EMIT1 = ST_EMIT1;
  localparam logic [1:0] EMIT0 = ST_EMIT0;

  logic [1:0] state;
  round_key_t key_reg;
  logic [7:0] a, b, b_next, a_next, sub_out, rc;
  logic       xfer;

  assign a      = key_reg[15:8];
  assign b      = key_reg[7:0];
  assign b_next = a ^ b;
  assign xfer   = key_valid & key_ready;
  assign rc     = (state == EMIT2) ? RCON2 : RCON1;

  // SubNib works per nibble, so SubNib(RotNib(x)) == RotNib(SubNib(x)); this
  // lets the single substitution instance sit directly on a ^ b.
  nibble_substitution u_sub (
    .encrypt (1'b1),
    .din     (b_next),
    .dout    (sub_out)
  );

  assign a_next  = a ^ rc ^ rot_nib(sub_out);
  assign key_out = key_reg;

  // Sequencer, working register and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_reg   <= '0;
      key_idx   <= 2'd0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= EMIT2;
            key_reg   <= key_in;
            key_idx   <= 2'd2;
            key_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        EMIT2: begin
          if (xfer) begin
            state   <= EMIT1;
            key_reg <= {a_next, b_next};
            key_idx <= 2'd1;
          end
        end
        EMIT1: begin
          if (xfer) begin
            state   <= EMIT0;
            key_reg <= {a_next, b_next};
            key_idx <= 2'd0;
          end
        end
        EMIT0: begin
          if (xfer) begin
            state     <= IDLE;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          key_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
